// File: rtl/fetch_exec_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_exec_ctrl
// Sequencing controller for the 4-bit nibble processor fetch path.
// It steps through WAIT -> FETCH -> EXEC. In EXEC it decodes the opcode
// nibble into datapath strobes. Opcode D sends the machine to HALT, and
// only reset leaves HALT.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   run        : 1 = sequence instructions, 0 = park in WAIT
//   Instr      : opcode nibble from the fetch register (used in EXEC only)
//   c_flag     : registered carry flag
//   z_flag     : registered zero flag
//   enablePG   : PC increment strobe
//   enableFTCH : fetch register load strobe
//   loadPC     : PC parallel load (jump taken)
//   loadA      : accumulator load
//   loadFlags  : C/Z flag register load
//   loadOut    : output port register load
//   oeOprnd    : drive the operand nibble onto the bus
//   oeIn       : drive the input port onto the bus
//   oeALU      : drive the ALU result onto the bus
//   aluSel     : 000 PASS_B, 001 ADD, 010 SUB, 011 NAND
//   halted     : high while in HALT
//   state_o    : 00 WAIT, 01 FETCH, 10 EXEC, 11 HALT
//
// Parameter
//   WAIT_CYCLES : ROM settle cycles before each FETCH (0..15)
// ---------------------------------------------------------------------------
module fetch_exec_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] Instr,
    input  logic       c_flag,
    input  logic       z_flag,
    output logic       enablePG,
    output logic       enableFTCH,
    output logic       loadPC,
    output logic       loadA,
    output logic       loadFlags,
    output logic       loadOut,
    output logic       oeOprnd,
    output logic       oeIn,
    output logic       oeALU,
    output logic [2:0] aluSel,
    output logic       halted,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_NAND   = 3'b011;

    state_t     state_r;
    logic [3:0] wait_cnt_r;

    // State register and ROM-settle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (!run) begin
                        // While parked, the settle count restarts from zero.
                        wait_cnt_r <= 4'd0;
                    end else if (wait_cnt_r == WAIT_LIM) begin
                        wait_cnt_r <= 4'd0;
                        state_r    <= ST_FETCH;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                ST_FETCH: state_r <= ST_EXEC;
                // EXEC always completes, whatever the value of run.
                ST_EXEC:  state_r <= (Instr == 4'hD) ? ST_HALT : ST_WAIT;
                ST_HALT:  state_r <= ST_HALT;
                default:  state_r <= ST_WAIT;
            endcase
        end
    end

    // Strobe decode: depends on state only, plus Instr and the flags in EXEC.
    always_comb begin
        enablePG   = 1'b0;
        enableFTCH = 1'b0;
        loadPC     = 1'b0;
        loadA      = 1'b0;
        loadFlags  = 1'b0;
        loadOut    = 1'b0;
        oeOprnd    = 1'b0;
        oeIn       = 1'b0;
        oeALU      = 1'b0;
        aluSel     = ALU_PASS_B;
        halted     = 1'b0;
        case (state_r)
            ST_FETCH: enableFTCH = 1'b1;
            ST_HALT:  halted     = 1'b1;
            ST_EXEC: begin
                enablePG = 1'b1;
                case (Instr)
                    4'h1: begin
                        oeOprnd = 1'b1; oeALU = 1'b1; loadA = 1'b1;
                        aluSel  = ALU_PASS_B;
                    end
                    4'h2: begin
                        oeOprnd = 1'b1; oeALU = 1'b1; loadA = 1'b1; loadFlags = 1'b1;
                        aluSel  = ALU_ADD;
                    end
                    4'h3: begin
                        oeOprnd = 1'b1; oeALU = 1'b1; loadA = 1'b1; loadFlags = 1'b1;
                        aluSel  = ALU_SUB;
                    end
                    4'h4: begin
                        oeOprnd = 1'b1; oeALU = 1'b1; loadA = 1'b1; loadFlags = 1'b1;
                        aluSel  = ALU_NAND;
                    end
                    // Compare only updates the flags; the result is not put on the bus.
                    4'h5: begin
                        oeOprnd = 1'b1; loadFlags = 1'b1;
                        aluSel  = ALU_SUB;
                    end
                    4'h6: begin
                        oeIn   = 1'b1; oeALU = 1'b1; loadA = 1'b1;
                        aluSel = ALU_PASS_B;
                    end
                    4'h7: loadOut = 1'b1;
                    4'h8: begin
                        loadPC = 1'b1; enablePG = 1'b0;
                    end
                    4'h9: begin
                        if (c_flag) begin
                            loadPC = 1'b1; enablePG = 1'b0;
                        end else begin
                            loadPC = 1'b0;
                        end
                    end
                    4'hA: begin
                        if (!c_flag) begin
                            loadPC = 1'b1; enablePG = 1'b0;
                        end else begin
                            loadPC = 1'b0;
                        end
                    end
                    4'hB: begin
                        if (z_flag) begin
                            loadPC = 1'b1; enablePG = 1'b0;
                        end else begin
                            loadPC = 1'b0;
                        end
                    end
                    4'hC: begin
                        if (!z_flag) begin
                            loadPC = 1'b1; enablePG = 1'b0;
                        end else begin
                            loadPC = 1'b0;
                        end
                    end
                    4'hD:    enablePG = 1'b0;
                    default: enablePG = 1'b1;   // 0, E, F behave as NOP
                endcase
            end
            default: halted = 1'b0;
        endcase
    end

    assign state_o = state_r;

endmodule
